ref_clk_gen: RTL and testbench

- Synthesizable reference-clock generator. Divides the system clock by a programmable integer ratio to produce a slow, free-running reference clock, for example about 32.768 kHz (period 30517 ns) from 100 MHz.
- Sits beside the SoC/JTAG test logic and feeds slow-clock consumers.
- Provides a glitch-free ratio update, an enable, and a per-period tick.

---
 rtl/ref_clk_gen.sv | 128 ++++++++++++
 tb/tb_ref_clk_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ref_clk_gen.sv
// Programmable integer divider producing a free-running flop-driven reference clock plus per-period tick.
// Latency: clk_o/tick_o rise one edge after en_i is sampled high; ratio ack one cycle after the boundary. No backpressure.
module ref_clk_gen #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 3052
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ack_o,
  output logic                 clk_o,
  output logic                 tick_o
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO   = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DEF   = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH:0]   ONE_W = (DIV_WIDTH+1)'(1);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] pdiv_q, pdiv_d;
  logic                 pend_q, pend_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic                 ack_q, ack_d;

  logic                 wrap;
  logic                 xfer;
  logic [DIV_WIDTH-1:0] n_next;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic [DIV_WIDTH:0]   h_next;

  // A pending ratio only lands on a period boundary (or straight away while idle),
  // so the high/low split of a running period never changes mid-flight.
  assign wrap    = (state_q == RUN) && (cnt_q == div_q - ONE);
  assign xfer    = pend_q && ((state_q == IDLE) || wrap);
  assign n_next  = xfer ? ((pdiv_q < TWO) ? TWO : pdiv_q) : div_q;
  assign h_next  = ({1'b0, n_next} + ONE_W) >> 1;
  assign cnt_inc = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    pdiv_d  = pdiv_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    ack_d   = 1'b0;

    if (xfer) begin
      div_d  = n_next;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end
    // A request arriving on a transfer edge stays pending for the next boundary.
    if (div_valid_i) begin
      pdiv_d = div_i;
      pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = RUN;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end else begin
          clk_d   = 1'b0;
        end
      end
      RUN: begin
        if (wrap) begin
          cnt_d = '0;
          if (en_i) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = ({1'b0, cnt_inc} < h_next);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DEF;
      pdiv_q  <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pdiv_q  <= pdiv_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      ack_q   <= ack_d;
    end
  end

  assign clk_o     = clk_q;
  assign tick_o    = tick_q;
  assign div_ack_o = ack_q;

endmodule

// File: tb/tb_ref_clk_gen.sv
// Directed bench for ref_clk_gen: expected {clk_o,tick_o,div_ack_o} per cycle are queued
// from H/L period patterns and compared every cycle on the falling edge.
module tb_ref_clk_gen;

  localparam int DW = 16;

  logic          clk_i;
  logic          rst_ni;
  logic          en_i;
  logic [DW-1:0] div_i;
  logic          div_valid_i;
  logic          div_ack_o;
  logic          clk_o;
  logic          tick_o;

  ref_clk_gen #(.DIV_WIDTH(DW), .DEFAULT_DIV(3052)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ack_o   (div_ack_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  logic [2:0] sb[$];
  int         total  = 0;
  int         passed = 0;
  int         cyc    = 0;
  string      phase  = "init";

  function automatic int clampn(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s cycle %0d: observed clk/tick/ack=%b expected %b", tag, cyc, got, exp);
  endtask

  task automatic push_period(input int n, input bit ack);
    int h;
    logic [2:0] e;
    h = (n + 1) / 2;
    for (int i = 0; i < n; i++) begin
      e = {(i < h), (i == 0), (ack && (i == 0))};
      sb.push_back(e);
    end
  endtask

  task automatic push_const(input int n, input logic [2:0] e);
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic step(input int n);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      cyc++;
      if (sb.size() == 0) begin
        total++;
        $error("FAIL %s cycle %0d: scoreboard empty, observed %b expected queued entry", phase, cyc,
               {clk_o, tick_o, div_ack_o});
      end else begin
        e = sb.pop_front();
        chk(phase, {clk_o, tick_o, div_ack_o}, e);
      end
    end
  endtask

  // Request issued one cycle into a period of n_cur; optional second request next cycle.
  task automatic do_req(input int n_cur, input int v1, input bit two, input int v2);
    int n_new;
    push_period(n_cur, 1'b0);
    step(1);
    div_valid_i = 1'b1;
    div_i       = DW'(v1);
    step(1);
    if (two) begin
      div_i = DW'(v2);
      step(1);
    end
    div_valid_i = 1'b0;
    step(n_cur - (two ? 3 : 2));
    n_new = clampn(two ? v2 : v1);
    push_period(n_new, 1'b1);
    push_period(n_new, 1'b0);
    step(2 * n_new);
  endtask

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b0;
    div_i       = '0;
    div_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_outputs", {clk_o, tick_o, div_ack_o}, 3'b000);
    rst_ni = 1'b1;

    phase = "idle100";
    push_const(100, 3'b000);
    step(100);

    phase = "default_then_5";
    en_i = 1'b1;
    push_period(3052, 1'b0);
    step(1500);
    div_valid_i = 1'b1;
    div_i       = DW'(5);
    step(1);
    div_valid_i = 1'b0;
    step(1551);
    push_period(5, 1'b1);
    push_period(5, 1'b0);
    push_period(5, 1'b0);
    step(15);

    phase = "div0";      do_req(5, 0, 1'b0, 0);
    phase = "div1";      do_req(2, 1, 1'b0, 0);
    phase = "div7";      do_req(2, 7, 1'b0, 0);
    phase = "b2b_9_4";   do_req(7, 9, 1'b1, 4);

    phase = "coincident";
    push_period(4, 1'b0);
    step(1);
    div_valid_i = 1'b1;
    div_i       = DW'(6);
    step(1);
    div_valid_i = 1'b0;
    step(2);
    div_valid_i = 1'b1;
    div_i       = DW'(3);
    push_period(6, 1'b1);
    step(1);
    div_valid_i = 1'b0;
    step(5);
    push_period(3, 1'b1);
    push_period(3, 1'b0);
    step(6);

    phase = "to10";      do_req(3, 10, 1'b0, 0);

    phase = "en_drop";
    push_period(10, 1'b0);
    step(1);
    en_i = 1'b0;
    step(9);
    push_const(20, 3'b000);
    step(20);

    phase = "idle_xfer7";
    div_valid_i = 1'b1;
    div_i       = DW'(7);
    push_const(1, 3'b000);
    step(1);
    div_valid_i = 1'b0;
    push_const(1, 3'b001);
    push_const(3, 3'b000);
    step(4);

    phase = "reenable";
    en_i = 1'b1;
    push_period(7, 1'b0);
    push_period(7, 1'b0);
    step(14);

    phase = "seamless";
    push_period(7, 1'b0);
    step(2);
    en_i = 1'b0;
    step(3);
    en_i = 1'b1;
    step(2);
    push_period(7, 1'b0);
    step(7);

    phase = "reset_mid_high";
    push_period(7, 1'b0);
    step(2);
    #2;
    rst_ni = 1'b0;
    en_i   = 1'b0;
    #1;
    chk("reset_async", {clk_o, tick_o, div_ack_o}, 3'b000);
    sb.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_const(5, 3'b000);
    step(5);

    phase = "default_after_reset";
    en_i = 1'b1;
    push_period(3052, 1'b0);
    step(1);
    en_i = 1'b0;
    step(3051);
    push_const(5, 3'b000);
    step(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
